regfile_sb: RTL and testbench

Parametrised, clocked register file for the MIPS datapath, replacing the combinational single-write/two-read array. Provides NUM_RD asynchronous read ports with same-cycle write-through bypass, one synchronous write port, a hardwired-zero register 0, and a per-register busy scoreboard for long-latency producers such as loads. Sits between decode, which reads and reserves, and writeback, which writes and releases.

---
 rtl/regfile_pkg.sv | 27 ++
 rtl/regfile_scoreboard.sv | 40 ++++
 rtl/regfile_sb.sv | 72 +++++++
 tb/tb_regfile_sb.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants for the MIPS register file.
// Default geometry plus ABI register names.
package regfile_pkg;

   localparam int RF_DATA_W   = 32;
   localparam int RF_NUM_REGS = 32;
   localparam int RF_ZERO_REG = 0;

   localparam int T0 = 8;
   localparam int T1 = 9;
   localparam int T2 = 10;
   localparam int T3 = 11;
   localparam int T4 = 12;
   localparam int T5 = 13;
   localparam int T6 = 14;
   localparam int T7 = 15;

   localparam int S0 = 16;
   localparam int S1 = 17;
   localparam int S2 = 18;
   localparam int S3 = 19;
   localparam int S4 = 20;
   localparam int S5 = 21;
   localparam int S6 = 22;
   localparam int S7 = 23;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits.
// Reserve wins over a same-cycle release; register 0 never busy.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter  int NUM_REGS = RF_NUM_REGS,
   localparam int AW       = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic                rsv_en,
   input  logic [AW-1:0]       rsv_addr,
   output logic [NUM_REGS-1:0] busy_vec
);

   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_nxt;

   // The reserve belongs to a newer producer, so it is applied last.
   always_comb begin
      busy_nxt = busy;
      if (wr_en)
         busy_nxt[wr_addr] = 1'b0;
      if (rsv_en)
         busy_nxt[rsv_addr] = 1'b1;
      busy_nxt[RF_ZERO_REG] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         busy <= '0;
      else
         busy <= busy_nxt;
   end

   assign busy_vec = busy;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with write-through bypass and busy scoreboard.
// NUM_RD combinational read ports, one synchronous write port.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter  int DATA_W   = RF_DATA_W,
   parameter  int NUM_REGS = RF_NUM_REGS,
   parameter  int NUM_RD   = 2,
   localparam int AW       = $clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD*AW-1:0]     rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     wr_en,
   input  logic [AW-1:0]            wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     rsv_en,
   input  logic [AW-1:0]            rsv_addr,
   output logic [NUM_REGS-1:0]      busy_vec
);

   localparam logic [AW-1:0] ZERO = AW'(RF_ZERO_REG);

   logic [DATA_W-1:0] mem [NUM_REGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         mem <= '{default: '0};
      else if (wr_en && wr_addr != ZERO)
         mem[wr_addr] <= wr_data;
   end

   regfile_scoreboard #(
      .NUM_REGS (NUM_REGS)
   ) u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .busy_vec (busy_vec)
   );

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [AW-1:0]     addr;
      logic [DATA_W-1:0] data;
      logic              bsy;

      assign addr = rd_addr[p*AW +: AW];

      // Reset gating keeps a bypassed wr_data off the port during reset.
      always_comb begin
         data = '0;
         bsy  = 1'b0;
         if (rst_n && addr != ZERO) begin
            if (wr_en && wr_addr == addr) begin
               data = wr_data;
            end else begin
               data = mem[addr];
               bsy  = busy_vec[addr];
            end
         end
      end

      assign rd_data[p*DATA_W +: DATA_W] = data;
      assign rd_busy[p]                  = bsy;
   end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed bench with an expected-value queue.
// Expectations are queued at stimulus time and popped at each check.
module tb_regfile_sb;
   import regfile_pkg::*;

   localparam int DW = 32;
   localparam int NR = 32;
   localparam int NP = 2;
   localparam int AW = 5;

   logic             clk;
   logic             rst_n;
   logic [NP*AW-1:0] rd_addr;
   logic [NP*DW-1:0] rd_data;
   logic [NP-1:0]    rd_busy;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [DW-1:0]    wr_data;
   logic             rsv_en;
   logic [AW-1:0]    rsv_addr;
   logic [NR-1:0]    busy_vec;

   int tests = 0;
   int fails = 0;
   logic [63:0] exp_q [$];

   regfile_sb #(
      .DATA_W   (DW),
      .NUM_REGS (NR),
      .NUM_RD   (NP)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_busy  (rd_busy),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .busy_vec (busy_vec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push(input logic [63:0] e);
      exp_q.push_back(e);
   endtask

   task automatic cmp(input string tag, input logic [63:0] obs);
      logic [63:0] e;
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $error("FAIL %s: observed %h, no expected value queued", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic rd(input int a0, input int a1);
      rd_addr = {AW'(a1), AW'(a0)};
   endtask

   function automatic logic [63:0] d0();
      return 64'(rd_data[DW-1:0]);
   endfunction

   function automatic logic [63:0] d1();
      return 64'(rd_data[2*DW-1:DW]);
   endfunction

   initial begin
      rst_n    = 1'b0;
      rd_addr  = '0;
      wr_en    = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      rsv_en   = 1'b0;
      rsv_addr = '0;

      // outputs during reset, even with a matching write present
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hFFFF_0000;
      rd(3, 3);
      #3;
      push(64'd0); cmp("rst_rd_data", 64'(rd_data));
      push(64'd0); cmp("rst_rd_busy", 64'(rd_busy));
      push(64'd0); cmp("rst_busy_vec", 64'(busy_vec));
      wr_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      for (int a = 0; a < NR; a++) begin
         rd(a, NR - 1 - a);
         #1;
         push(64'd0); cmp("init_rd_data", 64'(rd_data));
         push(64'd0); cmp("init_rd_busy", 64'(rd_busy));
      end
      push(64'd0); cmp("init_busy_vec", 64'(busy_vec));

      // bypass then storage
      step();
      wr_en = 1'b1; wr_addr = 5'(T0); wr_data = 32'hDEAD_BEEF;
      rd(T0, T1);
      #1;
      push(64'hDEAD_BEEF); cmp("byp_t0", d0());
      push(64'd0);         cmp("byp_t1_other", d1());
      push(64'd0);         cmp("byp_busy", 64'(rd_busy));
      step();
      wr_en = 1'b0;
      rd(T1, T0);
      #1;
      push(64'hDEAD_BEEF); cmp("store_t0_p1", d1());
      push(64'd0);         cmp("store_t1_p0", d0());

      // register zero
      step();
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234_5678;
      rd(0, 0);
      #1;
      push(64'd0); cmp("zero_byp", 64'(rd_data));
      step();
      wr_en = 1'b0;
      rsv_en = 1'b1; rsv_addr = 5'd0;
      #1;
      push(64'd0); cmp("zero_store", 64'(rd_data));
      step();
      rsv_en = 1'b0;
      #1;
      push(64'd0); cmp("zero_busy_vec0", 64'(busy_vec[0]));
      push(64'd0); cmp("zero_rd_busy", 64'(rd_busy));

      // reserve then release with bypass
      step();
      rsv_en = 1'b1; rsv_addr = 5'(S0);
      rd(S0, S0);
      #1;
      push(64'd0); cmp("rsv_no_comb", 64'(rd_busy));
      step();
      rsv_en = 1'b0;
      #1;
      push(64'd3); cmp("rsv_busy", 64'(rd_busy));
      push(64'(32'h0001_0000)); cmp("rsv_busy_vec", 64'(busy_vec));
      step();
      wr_en = 1'b1; wr_addr = 5'(S0); wr_data = 32'hA5A5_A5A5;
      #1;
      push(64'd0);         cmp("rel_byp_busy", 64'(rd_busy));
      push(64'hA5A5_A5A5); cmp("rel_byp_data", d0());
      step();
      wr_en = 1'b0;
      #1;
      push(64'd0);         cmp("rel_busy_vec", 64'(busy_vec));
      push(64'hA5A5_A5A5); cmp("rel_store", d1());

      // reserve and write same register, same cycle
      step();
      wr_en = 1'b1; wr_addr = 5'(S1); wr_data = 32'h55;
      rsv_en = 1'b1; rsv_addr = 5'(S1);
      rd(S0, S1);
      #1;
      push(64'h55); cmp("rw_byp_data", d1());
      push(64'd0);  cmp("rw_byp_busy", 64'(rd_busy));
      step();
      wr_en = 1'b0;
      rsv_en = 1'b1; rsv_addr = 5'(S1);
      #1;
      push(64'h55);            cmp("rw_store", d1());
      push(64'd2);             cmp("rw_rd_busy", 64'(rd_busy));
      push(64'(32'h0002_0000)); cmp("rw_busy_vec", 64'(busy_vec));
      // re-reserve a busy register, write a non-busy one
      step();
      rsv_en = 1'b0;
      wr_en = 1'b1; wr_addr = 5'(T3); wr_data = 32'h0BAD_F00D;
      step();
      wr_en = 1'b0;
      rd(T3, S1);
      #1;
      push(64'h0BAD_F00D);      cmp("nb_store", d0());
      push(64'd2);              cmp("nb_rd_busy", 64'(rd_busy));
      push(64'(32'h0002_0000)); cmp("rersv_busy_vec", 64'(busy_vec));

      // async reset pulse between edges
      step();
      wr_en = 1'b1; wr_addr = 5'(T1); wr_data = 32'h7;
      step();
      wr_en = 1'b0;
      rsv_en = 1'b1; rsv_addr = 5'(T2);
      step();
      rsv_en = 1'b0;
      rd(T1, T2);
      #1;
      push(64'h7); cmp("pre_rst_t1", d0());
      push(64'd2); cmp("pre_rst_busy", 64'(rd_busy));
      #1;
      rst_n = 1'b0;
      #1;
      push(64'd0); cmp("arst_rd_data", 64'(rd_data));
      push(64'd0); cmp("arst_rd_busy", 64'(rd_busy));
      push(64'd0); cmp("arst_busy_vec", 64'(busy_vec));
      #1;
      rst_n = 1'b1;
      #1;
      push(64'd0); cmp("post_rst_data", 64'(rd_data));
      push(64'd0); cmp("post_rst_busy", 64'(rd_busy));

      // write and reserve on an edge held in reset are lost
      step();
      wr_en = 1'b1; wr_addr = 5'(T4); wr_data = 32'hCAFE;
      rsv_en = 1'b1; rsv_addr = 5'(T5);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      wr_en = 1'b0;
      rsv_en = 1'b0;
      rd(T4, T5);
      #1;
      push(64'd0); cmp("lost_wr", 64'(rd_data));
      push(64'd0); cmp("lost_rsv", 64'(rd_busy));

      // first edge after reset release behaves normally
      wr_en = 1'b1; wr_addr = 5'(T4); wr_data = 32'hBEEF;
      rsv_en = 1'b1; rsv_addr = 5'(T5);
      step();
      wr_en = 1'b0;
      rsv_en = 1'b0;
      #1;
      push(64'hBEEF); cmp("first_wr", d0());
      push(64'd2);    cmp("first_rsv", 64'(rd_busy));

      if (exp_q.size() != 0) begin
         fails++;
         $error("FAIL queue_drain: %0d expected values left", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
